// File: rtl/sram_cache_controller_pkg.sv
// rtl/sram_cache_controller_pkg.sv - shared constants and FSM encoding for the data cache
package sram_cache_controller_pkg;

  localparam logic [31:0] ADDR_OFFSET    = 32'd1024;
  localparam int          WORD_ADDR_BITS = 17;
  localparam int          INDEX_BITS     = 6;
  localparam int          TAG_BITS       = WORD_ADDR_BITS - INDEX_BITS - 1;
  localparam int          NUM_LINES      = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL0 = 2'd1,
    FILL1 = 2'd2,
    WRITE = 2'd3
  } cache_state_t;

endpackage

// File: rtl/sram_cache_controller_cache_line_array.sv
// rtl/sram_cache_controller_cache_line_array.sv - register-based valid/tag/data store, two words per line
module sram_cache_controller_cache_line_array
  import sram_cache_controller_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [31:0]           rd_data0,
  output logic [31:0]           rd_data1,
  input  logic                  line_we,
  input  logic [INDEX_BITS-1:0] line_index,
  input  logic [TAG_BITS-1:0]   line_tag,
  input  logic [31:0]           line_data0,
  input  logic [31:0]           line_data1,
  input  logic                  word_we,
  input  logic [INDEX_BITS-1:0] word_index,
  input  logic                  word_sel,
  input  logic [31:0]           word_data
);

  logic [NUM_LINES-1:0] valid;
  logic [TAG_BITS-1:0]  tag_mem   [NUM_LINES];
  logic [31:0]          data0_mem [NUM_LINES];
  logic [31:0]          data1_mem [NUM_LINES];

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data0 = data0_mem[rd_index];
  assign rd_data1 = data1_mem[rd_index];

  // Reset wins over a coincident fill, so an interrupted fill never becomes valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
    end else if (line_we) begin
      valid[line_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_mem[line_index]   <= line_tag;
      data0_mem[line_index] <= line_data0;
      data1_mem[line_index] <= line_data1;
    end else if (word_we) begin
      if (word_sel) begin
        data1_mem[word_index] <= word_data;
      end else begin
        data0_mem[word_index] <= word_data;
      end
    end
  end

endmodule

// File: rtl/sram_cache_controller.sv
// rtl/sram_cache_controller.sv - direct-mapped write-through data cache in front of the SRAM controller
module sram_cache_controller
  import sram_cache_controller_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        sram_rd_en,
  output logic        sram_wr_en,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  input  logic        sram_ready
);

  cache_state_t              state, state_next;
  logic [31:0]               rel_addr;
  logic [WORD_ADDR_BITS-1:0] w;
  logic                      word_sel;
  logic [INDEX_BITS-1:0]     index;
  logic [TAG_BITS-1:0]       tag;
  logic                      unused_addr_bits;
  logic [31:0]               line_base;
  logic [31:0]               fill_buf;
  logic                      line_valid;
  logic [TAG_BITS-1:0]       line_tag;
  logic [31:0]               line_data0, line_data1;
  logic                      hit, line_we, word_we;

  assign rel_addr         = address - ADDR_OFFSET;
  assign w                = rel_addr[WORD_ADDR_BITS+1:2];
  assign unused_addr_bits = ^{rel_addr[31:WORD_ADDR_BITS+2], rel_addr[1:0]};
  assign word_sel         = w[0];
  assign index            = w[INDEX_BITS:1];
  assign tag              = w[WORD_ADDR_BITS-1:INDEX_BITS+1];
  assign line_base = {{(30-WORD_ADDR_BITS){1'b0}}, w[WORD_ADDR_BITS-1:1], 1'b0, 2'b00} + ADDR_OFFSET;

  assign hit     = line_valid && (line_tag == tag);
  assign line_we = (state == FILL1) && sram_ready;
  assign word_we = (state == WRITE) && sram_ready && hit;

  sram_cache_controller_cache_line_array u_lines (
    .clk        (clk),
    .reset      (reset),
    .rd_index   (index),
    .rd_valid   (line_valid),
    .rd_tag     (line_tag),
    .rd_data0   (line_data0),
    .rd_data1   (line_data1),
    .line_we    (line_we),
    .line_index (index),
    .line_tag   (tag),
    .line_data0 (fill_buf),
    .line_data1 (sram_rdata),
    .word_we    (word_we),
    .word_index (index),
    .word_sel   (word_sel),
    .word_data  (wdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      fill_buf <= '0;
    end else begin
      state <= state_next;
      if ((state == FILL0) && sram_ready) begin
        fill_buf <= sram_rdata;
      end
    end
  end

  // Enables follow state only, so they fall the cycle after sram_ready leaves a state.
  always_comb begin
    state_next   = state;
    ready        = 1'b0;
    rdata        = '0;
    sram_rd_en   = 1'b0;
    sram_wr_en   = 1'b0;
    sram_address = '0;
    sram_wdata   = '0;
    case (state)
      IDLE: begin
        if (MEM_W_EN) begin
          state_next = WRITE;
        end else if (MEM_R_EN) begin
          if (hit) begin
            ready = 1'b1;
            rdata = word_sel ? line_data1 : line_data0;
          end else begin
            state_next = FILL0;
          end
        end else begin
          ready = 1'b1;
        end
      end
      FILL0: begin
        sram_rd_en   = 1'b1;
        sram_address = line_base;
        if (sram_ready) state_next = FILL1;
      end
      FILL1: begin
        sram_rd_en   = 1'b1;
        sram_address = line_base + 32'd4;
        if (sram_ready) state_next = IDLE;
      end
      WRITE: begin
        sram_wr_en   = 1'b1;
        sram_address = address;
        sram_wdata   = wdata;
        if (sram_ready) begin
          ready      = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sram_cache_controller.sv
// tb/tb_sram_cache_controller.sv - self-checking bench with SRAM and transaction-level cache model
module tb_sram_cache_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        MEM_R_EN, MEM_W_EN;
  logic [31:0] address, wdata, rdata;
  logic        ready, sram_rd_en, sram_wr_en, sram_ready;
  logic [31:0] sram_address, sram_wdata, sram_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [logic [31:0]];
  logic [1:0]  cnt;
  logic        sr_pulse, inject;
  bit          mvalid [64];
  int          mtag   [64];
  logic [31:0] got;

  always #5 clk = ~clk;

  sram_cache_controller dut (
    .clk          (clk),
    .reset        (reset),
    .MEM_R_EN     (MEM_R_EN),
    .MEM_W_EN     (MEM_W_EN),
    .address      (address),
    .wdata        (wdata),
    .rdata        (rdata),
    .ready        (ready),
    .sram_rd_en   (sram_rd_en),
    .sram_wr_en   (sram_wr_en),
    .sram_address (sram_address),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata),
    .sram_ready   (sram_ready)
  );

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h1000_0000 + a * 32'd3;
  endfunction

  function automatic int m_index(input logic [31:0] a);
    int unsigned wa;
    wa = (a - 32'd1024) >> 2;
    return int'((wa / 2) % 64);
  endfunction

  function automatic int m_tag(input logic [31:0] a);
    int unsigned wa;
    wa = (a - 32'd1024) >> 2;
    return int'((wa / 128) % 1024);
  endfunction

  // SRAM controller model: access completes 3 cycles after enable is seen, held enable restarts.
  always @(posedge clk) begin
    if (reset) begin
      cnt        <= 2'd0;
      sr_pulse   <= 1'b0;
      sram_rdata <= 32'd0;
    end else if ((sram_rd_en || sram_wr_en) && !sr_pulse) begin
      if (cnt == 2'd2) begin
        sr_pulse <= 1'b1;
        cnt      <= 2'd0;
        if (sram_rd_en) sram_rdata <= mem_rd(sram_address);
        if (sram_wr_en) mem[sram_address] = sram_wdata;
      end else begin
        cnt <= cnt + 2'd1;
      end
    end else begin
      sr_pulse   <= 1'b0;
      cnt        <= 2'd0;
      sram_rdata <= 32'd0;
    end
  end

  assign sram_ready = sr_pulse | inject;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] res);
    int          cyc, nrd, idx, tg;
    bit          miss;
    logic [31:0] raddr [$];
    logic [31:0] base;
    idx  = m_index(a);
    tg   = m_tag(a);
    miss = !(mvalid[idx] && mtag[idx] == tg);
    base = ((a - 32'd1024) & ~32'd7) + 32'd1024;
    @(negedge clk);
    MEM_R_EN = 1'b1; MEM_W_EN = 1'b0; address = a; wdata = 32'd0;
    cyc = 0; nrd = 0; res = 32'd0;
    for (int guard = 0; guard <= 40; guard++) begin
      #1;
      chk("rd_wr_en_low", {31'd0, sram_wr_en}, 32'd0);
      chk("rd_sram_wdata_zero", sram_wdata, 32'd0);
      if (sram_ready && sram_rd_en) begin
        nrd++;
        raddr.push_back(sram_address);
      end
      if (ready) begin
        res = rdata;
        chk("rd_rd_en_low_at_ready", {31'd0, sram_rd_en}, 32'd0);
        break;
      end
      chk("rd_rdata_zero_frozen", rdata, 32'd0);
      if (guard == 40) begin
        checks++; errors++;
        $display("FAIL rd_timeout: ready never rose for address %h", a);
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("rd_latency", cyc, miss ? 32'd9 : 32'd0);
    chk("rd_rdata", res, mem_rd(a));
    chk("rd_sram_reads", nrd, miss ? 32'd2 : 32'd0);
    if (miss && raddr.size() == 2) begin
      chk("rd_fill_addr0", raddr[0], base);
      chk("rd_fill_addr1", raddr[1], base + 32'd4);
    end
    if (miss) begin
      mvalid[idx] = 1'b1;
      mtag[idx]   = tg;
    end
    @(negedge clk);
    MEM_R_EN = 1'b0; address = 32'd0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    int cyc, nwr;
    @(negedge clk);
    MEM_W_EN = 1'b1; MEM_R_EN = 1'b0; address = a; wdata = d;
    cyc = 0; nwr = 0;
    for (int guard = 0; guard <= 40; guard++) begin
      #1;
      chk("wr_rd_en_low", {31'd0, sram_rd_en}, 32'd0);
      chk("wr_rdata_zero", rdata, 32'd0);
      if (sram_wr_en) begin
        chk("wr_sram_address", sram_address, a);
        chk("wr_sram_wdata", sram_wdata, d);
      end else begin
        chk("wr_wdata_zero_idle", sram_wdata, 32'd0);
      end
      if (sram_ready && sram_wr_en) nwr++;
      if (ready) break;
      if (guard == 40) begin
        checks++; errors++;
        $display("FAIL wr_timeout: ready never rose for address %h", a);
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("wr_latency", cyc, 32'd4);
    chk("wr_sram_writes", nwr, 32'd1);
    chk("wr_mem_updated", mem_rd(a), d);
    @(negedge clk);
    MEM_W_EN = 1'b0; address = 32'd0; wdata = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
    address = 32'd0; wdata = 32'd0; inject = 1'b0;
    for (int i = 0; i < 64; i++) begin
      mvalid[i] = 1'b0;
      mtag[i]   = 0;
    end
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ready", {31'd0, ready}, 32'd1);
    chk("reset_rd_en", {31'd0, sram_rd_en}, 32'd0);
    chk("reset_wr_en", {31'd0, sram_wr_en}, 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_sram_wdata", sram_wdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    do_read(32'h400, got);
    chk("t1_miss_data", got, 32'h1000_0C00);
    do_read(32'h404, got);
    chk("t2_hit_data", got, 32'h1000_0C0C);

    @(negedge clk);
    inject = 1'b1;
    #1;
    chk("idle_pulse_ready", {31'd0, ready}, 32'd1);
    chk("idle_pulse_rd_en", {31'd0, sram_rd_en}, 32'd0);
    @(negedge clk);
    inject = 1'b0;
    #1;
    chk("idle_pulse_after_rd_en", {31'd0, sram_rd_en}, 32'd0);
    chk("idle_pulse_after_wr_en", {31'd0, sram_wr_en}, 32'd0);
    chk("idle_pulse_after_ready", {31'd0, ready}, 32'd1);

    do_write(32'h400, 32'hDEAD_BEEF);
    do_read(32'h400, got);
    chk("t3_write_hit_data", got, 32'hDEAD_BEEF);

    do_write(32'h600, 32'h1234_5678);
    do_read(32'h404, got);
    chk("t4_line_kept", got, 32'h1000_0C0C);
    do_read(32'h600, got);
    chk("t4_write_miss_data", got, 32'h1234_5678);

    do_read(32'h400, got);
    chk("t5_conflict_a", got, 32'hDEAD_BEEF);
    do_read(32'h600, got);
    do_read(32'h400, got);

    @(negedge clk);
    MEM_R_EN = 1'b1; address = 32'h800;
    repeat (6) @(negedge clk);
    #1;
    chk("t6_fill1_rd_en", {31'd0, sram_rd_en}, 32'd1);
    chk("t6_fill1_addr", sram_address, 32'h804);
    reset = 1'b1; MEM_R_EN = 1'b0; address = 32'd0;
    @(negedge clk);
    #1;
    chk("t6_rd_en_dropped", {31'd0, sram_rd_en}, 32'd0);
    chk("t6_wr_en_dropped", {31'd0, sram_wr_en}, 32'd0);
    chk("t6_ready_after_reset", {31'd0, ready}, 32'd1);
    reset = 1'b0;
    for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
    do_read(32'h800, got);
    chk("t6_refill_data", got, 32'h1000_1800);
    do_read(32'h404, got);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
